// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//   MEM-stage load/store initiator for a word-organised, little-endian data
//   memory with asynchronous read and posedge write. One request is handled
//   at a time. Sub-word stores are done as read-modify-write: the old word is
//   read and captured in the accept cycle, then written back with one lane
//   replaced in the following cycle.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                  request fields (size 00 B, 01 H, 10 W, 11 bad)
//   rsp_valid, rsp_rdata,
//   rsp_err                    one-cycle completion pulse with result / error
//   mem_addr, mem_wdata,
//   mem_read_en, mem_write_en,
//   mem_rdata                  data memory interface (word-aligned address)
// -----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int WORDLENGTH = 32,
  parameter int DMEM_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [WORDLENGTH-1:0] req_addr,
  input  logic [WORDLENGTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [WORDLENGTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [WORDLENGTH-1:0] mem_addr,
  output logic [WORDLENGTH-1:0] mem_wdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [WORDLENGTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RMW_WRITE = 2'b01,
    S_DONE      = 2'b10
  } state_t;

  localparam logic [WORDLENGTH-1:0] LP_LIMIT = WORDLENGTH'(DMEM_BYTES);
  localparam logic [WORDLENGTH-1:0] LP_ZERO  = {WORDLENGTH{1'b0}};

  // Misaligned, out-of-range or illegal-size request.
  function automatic logic f_req_error(input logic [1:0]            size,
                                       input logic [WORDLENGTH-1:0] addr);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = addr[0];
      2'b10:   e = |addr[1:0];
      default: e = 1'b1;
    endcase
    return e | (addr >= LP_LIMIT);
  endfunction

  // Select the addressed lane of a word and sign/zero-extend it.
  function automatic logic [WORDLENGTH-1:0] f_load_extract(
      input logic [WORDLENGTH-1:0] word,
      input logic [1:0]            lo,
      input logic [1:0]            size,
      input logic                  sgn);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [WORDLENGTH-1:0] shb;
    logic [WORDLENGTH-1:0] shh;
    logic [WORDLENGTH-1:0] res;
    shb = word >> {lo, 3'b000};
    shh = word >> {lo[1], 4'b0000};
    b   = shb[7:0];
    h   = shh[15:0];
    case (size)
      2'b00:   res = {{(WORDLENGTH-8){sgn & b[7]}}, b};
      2'b01:   res = {{(WORDLENGTH-16){sgn & h[15]}}, h};
      2'b10:   res = word;
      default: res = LP_ZERO;
    endcase
    return res;
  endfunction

  // Replace the target byte/half lane of the old word with store data.
  function automatic logic [WORDLENGTH-1:0] f_store_merge(
      input logic [WORDLENGTH-1:0] old,
      input logic [15:0]           data,
      input logic [1:0]            lo,
      input logic                  half);
    logic [WORDLENGTH-1:0] mask;
    logic [WORDLENGTH-1:0] ins;
    if (half) begin
      mask = {{(WORDLENGTH-16){1'b0}}, 16'hFFFF} << {lo[1], 4'b0000};
      ins  = {{(WORDLENGTH-16){1'b0}}, data} << {lo[1], 4'b0000};
    end else begin
      mask = {{(WORDLENGTH-8){1'b0}}, 8'hFF} << {lo, 3'b000};
      ins  = {{(WORDLENGTH-8){1'b0}}, data[7:0]} << {lo, 3'b000};
    end
    return (old & ~mask) | (ins & mask);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORDLENGTH-1:0] r_addr;
  logic                  r_half;
  logic [15:0]           r_wdata;
  logic [WORDLENGTH-1:0] r_old;
  logic [WORDLENGTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_err;
  logic [WORDLENGTH-1:0] w_req_word_addr;
  logic                  w_mem_read_en;
  logic                  w_mem_write_en;
  logic [WORDLENGTH-1:0] w_mem_addr;
  logic [WORDLENGTH-1:0] w_mem_wdata;
  logic                  w_rsp_valid;
  logic [WORDLENGTH-1:0] w_rsp_rdata;
  logic                  w_rsp_err;

  assign w_ready         = (r_state == S_IDLE) & ~reset;
  assign w_accept        = req_valid & w_ready;
  assign w_err           = f_req_error(req_size, req_addr);
  assign w_req_word_addr = {req_addr[WORDLENGTH-1:2], 2'b00};

  // State register and request/result capture at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= LP_ZERO;
      r_half  <= 1'b0;
      r_wdata <= 16'h0000;
      r_old   <= LP_ZERO;
      r_rdata <= LP_ZERO;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_half  <= req_size[0];
        r_wdata <= req_wdata[15:0];
        r_old   <= mem_rdata;
        r_err   <= w_err;
        // Only error-free loads produce data; stores and errors return 0.
        r_rdata <= (w_err | req_write) ? LP_ZERO
                 : f_load_extract(mem_rdata, req_addr[1:0], req_size, req_signed);
      end
    end
  end

  // Next-state and memory/response drive.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_read_en  = 1'b0;
    w_mem_write_en = 1'b0;
    w_mem_addr     = LP_ZERO;
    w_mem_wdata    = LP_ZERO;
    w_rsp_valid    = 1'b0;
    w_rsp_rdata    = LP_ZERO;
    w_rsp_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
        end else if (w_err) begin
          w_state_nxt = S_DONE;
        end else if (!req_write) begin
          w_mem_read_en = 1'b1;
          w_mem_addr    = w_req_word_addr;
          w_state_nxt   = S_DONE;
        end else if (req_size == 2'b10) begin
          w_mem_write_en = 1'b1;
          w_mem_addr     = w_req_word_addr;
          w_mem_wdata    = req_wdata;
          w_state_nxt    = S_DONE;
        end else begin
          // Sub-word store: fetch the old word first.
          w_mem_read_en = 1'b1;
          w_mem_addr    = w_req_word_addr;
          w_state_nxt   = S_RMW_WRITE;
        end
      end
      S_RMW_WRITE: begin
        w_mem_write_en = 1'b1;
        w_mem_addr     = {r_addr[WORDLENGTH-1:2], 2'b00};
        w_mem_wdata    = f_store_merge(r_old, r_wdata, r_addr[1:0], r_half);
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        w_rsp_valid = 1'b1;
        w_rsp_rdata = r_rdata;
        w_rsp_err   = r_err;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Reset forces the memory interface and response quiet in the same cycle,
  // so an RMW write in flight is dropped and no stale response escapes.
  assign req_ready    = w_ready;
  assign mem_read_en  = w_mem_read_en  & ~reset;
  assign mem_write_en = w_mem_write_en & ~reset;
  assign mem_addr     = reset ? LP_ZERO : w_mem_addr;
  assign mem_wdata    = reset ? LP_ZERO : w_mem_wdata;
  assign rsp_valid    = w_rsp_valid & ~reset;
  assign rsp_rdata    = reset ? LP_ZERO : w_rsp_rdata;
  assign rsp_err      = w_rsp_err & ~reset;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  logic [32:0] sb_q [$];
  int          checks = 0;
  int          failures = 0;
  logic        prev_rsp = 1'b0;

  dmem_access_unit #(.WORDLENGTH(32), .DMEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: asynchronous read, write on posedge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Whole-run interface invariants.
  always @(negedge clk) begin
    checks++;
    if (mem_read_en && mem_write_en) begin
      failures++;
      $display("FAIL en_exclusive got rd=%0b wr=%0b expected not both", mem_read_en, mem_write_en);
    end
    checks++;
    if (rsp_valid && prev_rsp) begin
      failures++;
      $display("FAIL rsp_pulse got rsp_valid high two cycles expected single pulse");
    end
    prev_rsp = rsp_valid;
    checks++;
    if (mem_addr[1:0] !== 2'b00 || mem_addr >= 32'd1024) begin
      failures++;
      $display("FAIL mem_addr_range got=%h expected aligned and < 1024", mem_addr);
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input logic [31:0] exp_mwd, input string name);
    logic        rmw;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [32:0] exp;
    logic        got;
    int          lat;
    int          exp_lat;
    rmw      = wr && (sz != 2'b10) && !exp_err;
    exp_ren  = !exp_err && (!wr || sz != 2'b10);
    exp_wen  = !exp_err && wr && (sz == 2'b10);
    exp_addr = exp_err ? 32'h0 : {addr[31:2], 2'b00};
    exp_lat  = rmw ? 2 : 1;
    @(negedge clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL %s_ready got=0 expected=1 within 10 cycles", name);
      return;
    end
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    sb_q.push_back({exp_err, exp_rd});
    #1;
    checks++;
    if ({mem_read_en, mem_write_en} !== {exp_ren, exp_wen} || mem_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s_cycN got rd=%0b wr=%0b addr=%h expected rd=%0b wr=%0b addr=%h",
               name, mem_read_en, mem_write_en, mem_addr, exp_ren, exp_wen, exp_addr);
    end
    if (exp_wen) begin
      checks++;
      if (mem_wdata !== wd) begin
        failures++;
        $display("FAIL %s_sw_wdata got=%h expected=%h", name, mem_wdata, wd);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 5 && !got; c++) begin
      @(negedge clk);
      if (c == 1 && rmw) begin
        checks++;
        if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_wdata !== exp_mwd ||
            mem_addr !== exp_addr) begin
          failures++;
          $display("FAIL %s_rmw_write got wr=%0b rd=%0b wdata=%h addr=%h expected wr=1 rd=0 wdata=%h addr=%h",
                   name, mem_write_en, mem_read_en, mem_wdata, mem_addr, exp_mwd, exp_addr);
        end
      end
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    exp = sb_q.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout got no rsp_valid expected within 5 cycles", name);
    end else begin
      if (lat != exp_lat) begin
        failures++;
        $display("FAIL %s_latency got=%0d expected=%0d", name, lat, exp_lat);
      end
      checks++;
      if ({rsp_err, rsp_rdata} !== exp) begin
        failures++;
        $display("FAIL %s_rsp got err=%0b rdata=%h expected err=%0b rdata=%h",
                 name, rsp_err, rsp_rdata, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_in_reset got=%0b expected=0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%0b rv=%0b err=%0b rd=%0b wr=%0b expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h expected all 0",
               rsp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_loads();
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80FF_0000, 1'b0, 32'h0, 32'h0, "sw_init");
    do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, "lb");
    do_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 1'b0, 32'h0000_0080, 32'h0, "lbu");
    do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 1'b0, 32'hFFFF_80FF, 32'h0, "lh");
    do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0, 32'h0000_80FF, 32'h0, "lhu");
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0, 32'h0000_0000, 32'h0, "lb_zero");
    do_req(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 1'b0, 32'h80FF_0000, 32'h0, "lw_signed");
  endtask

  task automatic test_rmw();
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 1'b0, 32'h0, 32'h0, "sw_base1");
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h1234_56AB, 1'b0, 32'h0, 32'h1122_AB44, "sb");
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1122_AB44, 32'h0, "lw_after_sb");
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 1'b0, 32'h0, 32'h0, "sw_base2");
    do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_BEEF, 1'b0, 32'h0, 32'hBEEF_3344, "sh");
    do_req(1'b1, 2'b01, 1'b0, 32'h9, 32'h0000_CAFE, 1'b1, 32'h0, 32'h0, "sh_misaligned");
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'hBEEF_3344, 32'h0, "lw_after_sh");
    do_req(1'b1, 2'b00, 1'b0, 32'hB, 32'h0000_0077, 1'b0, 32'h0, 32'h77EF_3344, "sb_lane3");
    do_req(1'b1, 2'b01, 1'b0, 32'h8, 32'h0000_1357, 1'b0, 32'h0, 32'h77EF_1357, "sh_lane0");
  endtask

  task automatic test_errors();
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 32'h0, "lw_misaligned");
    do_req(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 1'b1, 32'h0, 32'h0, "lw_out_of_range");
    do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0, 32'h0, "size_illegal");
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h5, 1'b1, 32'h0, 32'h0, "store_size_illegal");
    do_req(1'b0, 2'b00, 1'b0, 32'd1024, 32'h0, 1'b1, 32'h0, 32'h0, "lb_out_of_range");
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA1B2_C3D4, 1'b0, 32'h0, 32'h0, "sw_top");
    do_req(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, 1'b0, 32'h0000_00A1, 32'h0, "lbu_top");
    do_req(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 1'b0, 32'hFFFF_A1B2, 32'h0, "lh_top");
    do_req(1'b0, 2'b00, 1'b1, 32'h3FC, 32'h0, 1'b0, 32'hFFFF_FFD4, 32'h0, "lb_top");
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    int          resp;
    int          acc_cyc;
    resp = 0;
    acc_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h5;
    req_valid = 1'b1;
    sb_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1;
    req_write = 1'b0; req_wdata = 32'h0;
    sb_q.push_back({1'b0, 32'h5});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_busy got=%0b expected=0", req_ready);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_rsp got rsp_valid expected none");
        end else begin
          exp = sb_q.pop_front();
          if ({rsp_err, rsp_rdata} !== exp) begin
            failures++;
            $display("FAIL b2b_rsp got err=%0b rdata=%h expected err=%0b rdata=%h",
                     rsp_err, rsp_rdata, exp[32], exp[31:0]);
          end
        end
        resp++;
      end
      if (req_valid && req_ready) begin
        acc_cyc = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc_cyc != 2) begin
      failures++;
      $display("FAIL b2b_accept_cycle got=%0d expected=2", acc_cyc);
    end
    checks++;
    if (resp != 2) begin
      failures++;
      $display("FAIL b2b_rsp_count got=%0d expected=2", resp);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid_rmw();
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 1'b0, 32'h0, 32'h0, "sw_pre_abort");
    @(negedge clk);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h8; req_wdata = 32'hCC;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_reset got wr=%0b rd=%0b rv=%0b expected 0 0 0",
               mem_write_en, mem_read_en, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en} !== 5'b10000 ||
        rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL abort_idle got ready=%0b rv=%0b err=%0b rd=%0b wr=%0b rdata=%h addr=%h wdata=%h expected idle zeros",
               req_ready, rsp_valid, rsp_err, mem_read_en, mem_write_en, rsp_rdata, mem_addr, mem_wdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_rsp got rsp_valid=1 expected=0");
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1122_3344, 32'h0, "lw_after_abort");
  endtask

  initial begin
    test_reset();
    test_loads();
    test_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
